// File: rtl/vga_frame_reader.sv
// vga_frame_reader: scans a 640x480@60 raster and fetches one dmem byte per
// image pixel through the VGA read port, emitting grey RGB plus sync/blank.
// The image is IMG_W x IMG_H bytes, each byte magnified SCALE x SCALE on screen.
// Optional feature macro: VGA_BORDER_EN -- paints the outer one-pixel ring of
// the active area and every active pixel outside the image solid red.
module vga_frame_reader #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_BASE = 0,
  parameter int IMG_W    = 25,
  parameter int IMG_H    = 25,
  parameter int SCALE    = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] avga,
  input  logic [31:0] rdvga,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW  = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int IXW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int IYW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [31:0] H_LAST   = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST   = 32'(V_TOTAL - 1);
  localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] IMG_XEND = 32'(IMG_W * SCALE);
  localparam logic [31:0] IMG_YEND = 32'(IMG_H * SCALE);

  logic [DW-1:0]  div_q, div_d;
  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [VW-1:0]  vcnt_q, vcnt_d;
  logic [SW-1:0]  sx_q, sx_d, sy_q, sy_d;
  logic [IXW-1:0] ix_q, ix_d;
  logic [IYW-1:0] iy_q, iy_d;
  logic [31:0]    row_base_q, row_base_d;
  logic [7:0]     r_q, r_d, g_q, g_d, b_q, b_d;
  logic           hs_q, hs_d, vs_q, vs_d, bl_q, bl_d, fs_q, fs_d;

  logic        pe, h_wrap, v_wrap, in_image, active;
  logic [31:0] h32, v32;
  logic        unused_rd_hi;

  // Only the low byte of the memory word carries the pixel.
  assign unused_rd_hi = ^rdvga[31:8];

  assign h32      = 32'(hcnt_q);
  assign v32      = 32'(vcnt_q);
  assign pe       = (div_q == DW'(CLK_DIV - 1));
  assign h_wrap   = (h32 == H_LAST);
  assign v_wrap   = (v32 == V_LAST);
  assign in_image = (h32 < IMG_XEND) && (v32 < IMG_YEND);
  assign active   = (h32 < 32'(H_ACTIVE)) && (v32 < 32'(V_ACTIVE));

  // Fetch address is combinational from the registered sub-counters.
  always_comb begin
    avga = 32'(IMG_BASE);
    if (in_image) avga = 32'(IMG_BASE) + row_base_q + 32'(ix_q);
  end

  // Raster and image sub-counter next state; everything moves only on pe.
  always_comb begin
    div_d      = pe ? '0 : div_q + 1'b1;
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    sx_d       = sx_q;
    ix_d       = ix_q;
    sy_d       = sy_q;
    iy_d       = iy_q;
    row_base_d = row_base_q;
    if (pe) begin
      hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
      if (h_wrap) begin
        sx_d = '0;
        ix_d = '0;
      end else if (!(ix_q == IXW'(IMG_W - 1) && sx_q == SW'(SCALE - 1))) begin
        if (sx_q == SW'(SCALE - 1)) begin
          sx_d = '0;
          ix_d = ix_q + 1'b1;
        end else begin
          sx_d = sx_q + 1'b1;
        end
      end
      if (h_wrap) begin
        vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
        if (v_wrap) begin
          sy_d       = '0;
          iy_d       = '0;
          row_base_d = '0;
        end else if (!(iy_q == IYW'(IMG_H - 1) && sy_q == SW'(SCALE - 1))) begin
          if (sy_q == SW'(SCALE - 1)) begin
            sy_d       = '0;
            iy_d       = iy_q + 1'b1;
            row_base_d = row_base_q + 32'(IMG_W);
          end else begin
            sy_d = sy_q + 1'b1;
          end
        end
      end
    end
  end

  // Output pixel for the current counters; registered on pe so it lags by one tick.
  always_comb begin
    hs_d = !((h32 >= HS_START) && (h32 < HS_END));
    vs_d = !((v32 >= VS_START) && (v32 < VS_END));
    bl_d = active;
    r_d  = (active && in_image) ? rdvga[7:0] : 8'h00;
    g_d  = r_d;
    b_d  = r_d;
`ifdef VGA_BORDER_EN
    if (active && (!in_image || h32 == 32'd0 || h32 == 32'(H_ACTIVE - 1) ||
                   v32 == 32'd0 || v32 == 32'(V_ACTIVE - 1))) begin
      r_d = 8'hFF;
      g_d = 8'h00;
      b_d = 8'h00;
    end
`endif
    fs_d = pe && h_wrap && v_wrap;
  end

  // State registers; frame_start is rewritten every clk so it is a single-clk pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      sx_q       <= '0;
      ix_q       <= '0;
      sy_q       <= '0;
      iy_q       <= '0;
      row_base_q <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      bl_q       <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      div_q      <= div_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      sx_q       <= sx_d;
      ix_q       <= ix_d;
      sy_q       <= sy_d;
      iy_q       <= iy_d;
      row_base_q <= row_base_d;
      fs_q       <= fs_d;
      if (pe) begin
        r_q  <= r_d;
        g_q  <= g_d;
        b_q  <= b_d;
        hs_q <= hs_d;
        vs_q <= vs_d;
        bl_q <= bl_d;
      end
    end
  end

  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign blank_n     = bl_q;
  assign frame_start = fs_q;

endmodule
